// File: rtl/tile_renderer.sv
// One 2048 board tile: holds its value, swaps it only at frame start, and draws the
// matching palette colour with a frame-counted pop animation. Output is zero outside the tile.
module tile_renderer #(
  parameter int unsigned XIDX        = 0,
  parameter int unsigned YIDX        = 0,
  parameter int unsigned TILE_LEN    = 117,
  parameter int unsigned LINE_LEN    = 3,
  parameter int unsigned OUTER_PADX  = 134,
  parameter int unsigned OUTER_PADY  = 35,
  parameter int unsigned ANIM_FRAMES = 8,
  parameter int unsigned INSET_STEP  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] counter_x,
  input  logic [9:0] counter_y,
  input  logic       frame_start,
  input  logic [3:0] val,
  input  logic       val_load,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       in_tile,
  output logic       busy
);

  localparam int unsigned PW    = 11;
  localparam int unsigned VW    = 4;
  localparam int unsigned CW    = $clog2(ANIM_FRAMES + 1);
  localparam int unsigned XPOS  = OUTER_PADX + XIDX * (TILE_LEN + LINE_LEN);
  localparam int unsigned YPOS  = OUTER_PADY + YIDX * (TILE_LEN + LINE_LEN);

  localparam logic [PW-1:0] X_LO   = PW'(XPOS);
  localparam logic [PW-1:0] X_HI   = PW'(XPOS + TILE_LEN);
  localparam logic [PW-1:0] X_LAST = PW'(XPOS + TILE_LEN - 1);
  localparam logic [PW-1:0] Y_LO   = PW'(YPOS);
  localparam logic [PW-1:0] Y_HI   = PW'(YPOS + TILE_LEN);
  localparam logic [PW-1:0] Y_LAST = PW'(YPOS + TILE_LEN - 1);

  typedef enum logic {IDLE = 1'b0, POP = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] anim_cnt, anim_cnt_nxt;
  logic [VW-1:0] cur_val, pend_val, apply_val_c;
  logic          pend_valid, apply_c, trigger_c;

  // Value to apply at this frame start: same-cycle load takes priority over the pending one.
  always_comb begin
    apply_c     = frame_start && (val_load || pend_valid);
    apply_val_c = val_load ? val : pend_val;
    trigger_c   = apply_c && (apply_val_c != '0) && (apply_val_c != cur_val);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_val    <= '0;
      pend_val   <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (apply_c) cur_val <= apply_val_c;
      if (frame_start) begin
        pend_valid <= 1'b0;
      end else if (val_load) begin
        pend_valid <= 1'b1;
        pend_val   <= val;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      anim_cnt <= '0;
    end else begin
      state    <= state_nxt;
      anim_cnt <= anim_cnt_nxt;
    end
  end

  // FSM next state: a triggering apply (re)starts the pop, otherwise count down per frame
  always_comb begin
    state_nxt    = state;
    anim_cnt_nxt = anim_cnt;
    if (trigger_c) begin
      state_nxt    = POP;
      anim_cnt_nxt = CW'(ANIM_FRAMES);
    end else if (state == POP && frame_start) begin
      if (anim_cnt <= CW'(1)) begin
        state_nxt    = IDLE;
        anim_cnt_nxt = '0;
      end else begin
        anim_cnt_nxt = anim_cnt - CW'(1);
      end
    end
  end

  // FSM outputs
  always_comb begin
    busy = (state == POP);
  end

  logic [PW-1:0] cx, cy, inset_c;
  logic          hit_c;

  always_comb begin
    cx      = {1'b0, counter_x};
    cy      = {1'b0, counter_y};
    hit_c   = (cx >= X_LO) && (cx < X_HI) && (cy >= Y_LO) && (cy < Y_HI);
    inset_c = (state == POP) ? PW'(PW'(anim_cnt) * PW'(INSET_STEP)) : '0;
  end

  logic          s1_hit;
  logic [PW-1:0] s1_dl, s1_dr, s1_dt, s1_db, s1_inset;
  logic [VW-1:0] s1_val;

  // Stage 1: hit flag, edge distances and the value/inset in effect for this pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hit   <= 1'b0;
      s1_dl    <= '0;
      s1_dr    <= '0;
      s1_dt    <= '0;
      s1_db    <= '0;
      s1_inset <= '0;
      s1_val   <= '0;
    end else begin
      s1_hit   <= hit_c;
      s1_dl    <= cx - X_LO;
      s1_dr    <= X_LAST - cx;
      s1_dt    <= cy - Y_LO;
      s1_db    <= Y_LAST - cy;
      s1_inset <= inset_c;
      s1_val   <= cur_val;
    end
  end

  function automatic logic [23:0] palette(input logic [VW-1:0] v);
    logic [23:0] rgb;
    case (v)
      4'd0:    rgb = 24'hCDC1B4;
      4'd1:    rgb = 24'hEEE4DA;
      4'd2:    rgb = 24'hEDE0C8;
      4'd3:    rgb = 24'hF2B179;
      4'd4:    rgb = 24'hF59563;
      4'd5:    rgb = 24'hF67C5F;
      4'd6:    rgb = 24'hF65E3B;
      4'd7:    rgb = 24'hEDCF72;
      4'd8:    rgb = 24'hEDCC61;
      4'd9:    rgb = 24'hEDC850;
      4'd10:   rgb = 24'hEDC53F;
      4'd11:   rgb = 24'hEDC22E;
      default: rgb = 24'h3C3A32;
    endcase
    return rgb;
  endfunction

  logic        border_c;
  logic [23:0] colour_c;

  // Pixels within the shrinking inset band show the empty colour
  always_comb begin
    border_c = (s1_dl < s1_inset) || (s1_dr < s1_inset) ||
               (s1_dt < s1_inset) || (s1_db < s1_inset);
    colour_c = palette(border_c ? VW'(0) : s1_val);
  end

  // Stage 2: final colour, zero outside so tiles can be ORed together
  always_ff @(posedge clk) begin
    if (rst) begin
      red     <= '0;
      green   <= '0;
      blue    <= '0;
      in_tile <= 1'b0;
    end else if (s1_hit) begin
      {red, green, blue} <= colour_c;
      in_tile            <= 1'b1;
    end else begin
      {red, green, blue} <= '0;
      in_tile            <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tile_renderer.sv
// Bench for tile_renderer at grid (1,2): directed test-plan scenarios, then random
// pixels/loads/frames against a cycle-level behavioural model of the tile.
module tb_tile_renderer;
  localparam int XI = 1;
  localparam int YI = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] counter_x, counter_y;
  logic       frame_start, val_load;
  logic [3:0] val;
  logic [7:0] red, green, blue;
  logic       in_tile, busy;

  always #5 clk = ~clk;

  tile_renderer #(.XIDX(XI), .YIDX(YI)) dut (
    .clk(clk), .rst(rst), .counter_x(counter_x), .counter_y(counter_y),
    .frame_start(frame_start), .val(val), .val_load(val_load),
    .red(red), .green(green), .blue(blue), .in_tile(in_tile), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int m_cur = 0, m_pend = 0, m_pend_v = 0, m_cnt = 0, m_pop = 0;
  logic [24:0] exp_s1 = '0, exp_out = '0;

  function automatic logic [23:0] pal(input int v);
    case (v)
      0: return 24'hCDC1B4;   1: return 24'hEEE4DA;   2: return 24'hEDE0C8;
      3: return 24'hF2B179;   4: return 24'hF59563;   5: return 24'hF67C5F;
      6: return 24'hF65E3B;   7: return 24'hEDCF72;   8: return 24'hEDCC61;
      9: return 24'hEDC850;  10: return 24'hEDC53F;  11: return 24'hEDC22E;
      default: return 24'h3C3A32;
    endcase
  endfunction

  function automatic logic [24:0] pix(input int cx, input int cy);
    int x0, y0, d, ins;
    x0 = 134 + XI * 120;
    y0 = 35 + YI * 120;
    if (!(cx >= x0 && cx < x0 + 117 && cy >= y0 && cy < y0 + 117)) return 25'd0;
    d = cx - x0;
    if (x0 + 116 - cx < d) d = x0 + 116 - cx;
    if (cy - y0 < d) d = cy - y0;
    if (y0 + 116 - cy < d) d = y0 + 116 - cy;
    ins = m_pop ? m_cnt * 6 : 0;
    return {1'b1, pal(d < ins ? 0 : m_cur)};
  endfunction

  // One clock: drive inputs, advance the model at the edge, check outputs mid-cycle
  task automatic step(input int cx, input int cy, input bit fs = 0, input bit vl = 0,
                      input int v = 0, input bit r = 0);
    logic [24:0] e;
    int nv;
    bit ap;
    counter_x = 10'(cx); counter_y = 10'(cy);
    frame_start = fs; val_load = vl; val = 4'(v); rst = r;
    e = r ? 25'd0 : pix(cx, cy);
    @(posedge clk);
    exp_out = r ? 25'd0 : exp_s1;
    exp_s1  = e;
    if (r) begin
      m_cur = 0; m_pend_v = 0; m_cnt = 0; m_pop = 0;
    end else if (fs) begin
      ap = vl || (m_pend_v != 0);
      nv = vl ? v : m_pend;
      if (ap && nv != 0 && nv != m_cur) begin
        m_pop = 1; m_cnt = 8;
      end else if (m_pop != 0) begin
        m_cnt--;
        if (m_cnt == 0) m_pop = 0;
      end
      if (ap) m_cur = nv;
      m_pend_v = 0;
    end else if (vl) begin
      m_pend_v = 1; m_pend = v;
    end
    @(negedge clk);
    check("pixel", {7'd0, in_tile, red, green, blue}, {7'd0, exp_out});
    check("busy", {31'd0, busy}, 32'(m_pop));
  endtask

  task automatic hold(input int cx, input int cy);
    step(cx, cy);
    step(cx, cy);
  endtask

  task automatic expect_out(input string tag, input logic [24:0] v);
    check(tag, {7'd0, in_tile, red, green, blue}, {7'd0, v});
  endtask

  initial begin
    rst = 1'b1; counter_x = '0; counter_y = '0;
    frame_start = 1'b0; val_load = 1'b0; val = '0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 1);
    expect_out("reset_out", 25'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    hold(254, 275); expect_out("tl_corner", {1'b1, 24'hCDC1B4});
    hold(253, 275); expect_out("left_of_tile", 25'd0);
    hold(370, 391); expect_out("br_corner", {1'b1, 24'hCDC1B4});
    hold(371, 391); expect_out("right_of_tile", 25'd0);
    hold(370, 392); expect_out("below_tile", 25'd0);

    step(312, 333, 0, 1, 3);
    hold(312, 333); expect_out("no_tear", {1'b1, 24'hCDC1B4});
    step(312, 333, 1);
    hold(312, 333); expect_out("applied", {1'b1, 24'hF2B179});
    check("pop_busy", {31'd0, busy}, 32'd1);
    hold(301, 333); expect_out("inset_in", {1'b1, 24'hCDC1B4});
    hold(302, 333); expect_out("inset_edge", {1'b1, 24'hF2B179});
    for (int i = 0; i < 7; i++) step(312, 333, 1);
    check("still_busy", {31'd0, busy}, 32'd1);
    step(312, 333, 1);
    check("pop_done", {31'd0, busy}, 32'd0);
    hold(254, 275); expect_out("full_tile", {1'b1, 24'hF2B179});

    step(312, 333, 0, 1, 5);
    step(312, 333, 0, 1, 7);
    step(312, 333, 1);
    for (int i = 0; i < 8; i++) step(312, 333, 1);
    hold(312, 333); expect_out("last_wins", {1'b1, 24'hEDCF72});
    step(312, 333, 1, 1, 2);
    check("same_cycle_busy", {31'd0, busy}, 32'd1);
    hold(312, 333); expect_out("same_cycle", {1'b1, 24'hEDE0C8});
    for (int i = 0; i < 8; i++) step(312, 333, 1);
    step(312, 333, 1, 1, 2);
    check("reload_same", {31'd0, busy}, 32'd0);
    step(312, 333, 1, 1, 0);
    check("load_zero", {31'd0, busy}, 32'd0);
    hold(312, 333); expect_out("empty", {1'b1, 24'hCDC1B4});

    step(312, 333, 1, 1, 3);
    for (int i = 0; i < 4; i++) step(312, 333, 1);
    check("mid_pop", {31'd0, busy}, 32'd1);
    step(312, 333, 0, 0, 0, 1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    expect_out("rst_out", 25'd0);
    hold(312, 333); expect_out("after_rst", {1'b1, 24'hCDC1B4});
    check("after_rst_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 6000; i++)
      step(int'($urandom_range(240, 395)), int'($urandom_range(260, 405)),
           $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
           int'($urandom_range(0, 15)), $urandom_range(0, 299) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
